ag32gbd_reg_server: RTL and testbench
=====================================

Name: ag32gbd_reg_server

Overview:
Responder side of the register-read handshake used by the pixel sampler. Owns the 1024x8 camera register/threshold memory: CPU-bridge writes go in on a simple strobe port, and sampler read requests are served back on a 4-phase level handshake. After reset it optionally sweeps the memory to zero and stalls reads until the sweep is complete.

Parameters:
ADDR_W, 10, memory address width; depth = 2**ADDR_W
DATA_W, 8, data width
RD_LATENCY, 1, memory read latency in sys_clock cycles (1 or 2)
CLEAR_ON_RESET, 1, when 1, zero-fill the whole memory after reset deassertion

Ports:
sys_clock  in  1  system clock, 100 MHz; all logic on its rising edge
sys_resetn  in  1  reset, asynchronous, active-low
HostWrEn  in  1  single-cycle write strobe from the CPU bridge
HostWrAddr  in  ADDR_W  write address
HostWrData  in  DATA_W  write data
RequestReadReg  in  1  read request level from the initiator
RegReadAddr  in  ADDR_W  read address; stable while RequestReadReg=1
RegReadOutput  out  DATA_W  read data; valid while RegReadDone=1
RegReadDone  out  1  read-complete level
ClearBusy  out  1  high while the post-reset zero sweep runs

Behaviour:
- Reset values: RegReadOutput=0, RegReadDone=0, ClearBusy=CLEAR_ON_RESET, FSM=S_CLEAR if CLEAR_ON_RESET else S_IDLE, clear counter=0. Memory contents are not reset by reset itself.
- Reset asserted mid-operation aborts any read or sweep immediately. The sweep restarts from address 0 when reset deasserts.
- One-hot FSM with states S_CLEAR, S_IDLE, S_ISSUE, S_WAIT, S_DONE.
- S_CLEAR:
  - Writes 0 to address = counter each cycle; counter increments.
  - On counter = 2**ADDR_W-1: write that last address, drop ClearBusy on the next edge, go to S_IDLE.
  - Sweep duration is exactly 2**ADDR_W cycles.
  - HostWrEn during the sweep is dropped (no queueing). Requests are held pending; RegReadDone stays 0.
- S_IDLE: if RequestReadReg=1 and RegReadDone=0, latch RegReadAddr and go to S_ISSUE.
- S_ISSUE: drive the memory read address. If HostWrEn=1 in this cycle, the write takes the single memory port and the read re-issues next cycle (stay in S_ISSUE). Otherwise go to S_WAIT.
- S_WAIT: count RD_LATENCY cycles, then register memory data into RegReadOutput, set RegReadDone=1, go to S_DONE.
- Write/read to the same address: the write always wins the port and the read is reissued after it, so the read returns the newly written data.
- S_DONE:
  - Hold RegReadDone=1 and RegReadOutput stable while RequestReadReg=1.
  - When RequestReadReg=0 is sampled: clear RegReadDone on that edge, go to S_IDLE.
  - A new request seen in S_IDLE is only accepted once RegReadDone=0. This gives the initiator a guaranteed low-Done cycle between transactions.
- Minimum read turnaround, request rise to Done rise: 2+RD_LATENCY cycles without a write collision; each colliding HostWrEn adds 1 cycle.
- HostWrEn outside S_ISSUE and S_CLEAR writes in the same cycle; no effect on the FSM.
- Address wrap: none. Addresses are exactly ADDR_W bits, and the sweep counter is ADDR_W+1 bits so it can detect the end.
- RequestReadReg dropped while in S_ISSUE or S_WAIT: the transaction still completes internally. RegReadDone then pulses for exactly 1 cycle (Done set, request seen low next edge, Done cleared).

Decomposition:
- Shared package (ag32gbd_pkg):
  - ADDR_W and DATA_W defaults.
  - The threshold-region base constant 10'h200.
  - The one-hot FSM state encodings.
- One sub-module: ag32gbd_reg_bram. Single-port inferred RAM with we, addr, wdata, registered rdata, and RD_LATENCY pipeline stages.

Test Plan:
- Sweep: reset release with CLEAR_ON_RESET=1 -> ClearBusy high for exactly 1024 cycles, then a read of 10'h2A5 returns 8'h00.
- Basic read: write 10'h200=8'h40, then raise RequestReadReg with addr 10'h200 -> RegReadDone rises 3 cycles later (RD_LATENCY=1) with 8'h40, and stays high until the request is dropped, then falls on the next edge.
- Back-to-back sampler pattern: three reads at 10'h200/201/202 holding 8'h40/8'h80/8'hC0, request dropped for 1 cycle between reads -> three values returned in order, and Done is low at least 1 cycle before each new Done.
- Collision: HostWrEn to 10'h203 with 8'h55 in the same cycle as S_ISSUE for 10'h203 -> read returns 8'h55 with latency +1.
- Reset mid-read: assert sys_resetn=0 while in S_WAIT -> RegReadDone=0 and RegReadOutput=0 immediately, and the sweep restarts from address 0.
- Early drop: request high 1 cycle only -> RegReadDone pulses exactly 1 cycle, and the next request is served normally.

Source files
------------

// File: rtl/ag32gbd_pkg.sv
// Shared definitions for the ag32gbd register server.
//   AG_ADDR_W / AG_DATA_W : default geometry of the register/threshold memory
//   THRESH_BASE           : first address of the threshold region
//   srvState_t            : one-hot state encoding of the read server FSM
package ag32gbd_pkg;

    localparam int AG_ADDR_W = 10;
    localparam int AG_DATA_W = 8;

    localparam logic [AG_ADDR_W-1:0] THRESH_BASE = 10'h200;

    typedef enum logic [4:0] {
        S_CLEAR = 5'b00001,
        S_IDLE  = 5'b00010,
        S_ISSUE = 5'b00100,
        S_WAIT  = 5'b01000,
        S_DONE  = 5'b10000
    } srvState_t;

endpackage

// File: rtl/ag32gbd_reg_bram.sv
// Single-port inferred RAM with a registered, RD_LATENCY-deep read path.
// Read-first: a write cycle returns the old contents on rdata.
// Ports:
//   sys_clock, sys_resetn : clock / async active-low reset (valid pipe only)
//   we, addr, wdata       : shared port; write when we=1
//   re                    : marks a cycle whose read result the owner wants
//   rdata                 : mem[addr] delayed RD_LATENCY cycles
//   rvalid                : re delayed RD_LATENCY cycles, aligned with rdata
module ag32gbd_reg_bram #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              sys_clock,
    input  logic              sys_resetn,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [DATA_W-1:0]     mem    [2**ADDR_W];
    logic [DATA_W-1:0]     rdPipe [RD_LATENCY];
    logic [RD_LATENCY-1:0] vldPipe;

    // Memory and data pipe carry no reset so the array maps onto block RAM.
    always_ff @(posedge sys_clock) begin
        if (we)
            mem[addr] <= wdata;
        rdPipe[0] <= mem[addr];
        for (int i = 1; i < RD_LATENCY; i++)
            rdPipe[i] <= rdPipe[i-1];
    end

    // Valid bits are reset so an aborted read cannot complete after reset.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            vldPipe <= '0;
        end else begin
            vldPipe[0] <= re;
            for (int i = 1; i < RD_LATENCY; i++)
                vldPipe[i] <= vldPipe[i-1];
        end
    end

    assign rdata  = rdPipe[RD_LATENCY-1];
    assign rvalid = vldPipe[RD_LATENCY-1];

endmodule

// File: rtl/ag32gbd_reg_server.sv
// Register-read responder for the pixel sampler.
// Owns the camera register/threshold memory. The CPU bridge writes through a
// single-cycle strobe port; the sampler reads over a 4-phase level handshake
// (RequestReadReg / RegReadDone). After reset the memory is optionally swept
// to zero, with reads stalled until the sweep finishes.
// Ports:
//   sys_clock, sys_resetn          : clock / async active-low reset
//   HostWrEn, HostWrAddr, HostWrData : CPU-bridge write strobe
//   RequestReadReg, RegReadAddr    : read request level and address
//   RegReadOutput, RegReadDone     : read data and completion level
//   ClearBusy                      : high while the zero sweep runs
module ag32gbd_reg_server
    import ag32gbd_pkg::*;
#(
    parameter int ADDR_W         = AG_ADDR_W,
    parameter int DATA_W         = AG_DATA_W,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              sys_clock,
    input  logic              sys_resetn,
    input  logic              HostWrEn,
    input  logic [ADDR_W-1:0] HostWrAddr,
    input  logic [DATA_W-1:0] HostWrData,
    input  logic              RequestReadReg,
    input  logic [ADDR_W-1:0] RegReadAddr,
    output logic [DATA_W-1:0] RegReadOutput,
    output logic              RegReadDone,
    output logic              ClearBusy
);

    localparam int              DEPTH     = 2**ADDR_W;
    // Counter is one bit wider than the address so the end is unambiguous.
    localparam logic [ADDR_W:0] CLR_LAST  = (ADDR_W+1)'(DEPTH-1);
    localparam srvState_t       RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    srvState_t         state, stateNext;
    logic [ADDR_W:0]   clrCnt;
    logic [ADDR_W-1:0] rdAddr;

    logic              memWe;
    logic              memRe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memRvalid;

    logic              acceptReq;

    // A new request is only taken once the previous Done has been seen low.
    assign acceptReq = (state == S_IDLE) && RequestReadReg && !RegReadDone;

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn)
            state <= RST_STATE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        memWe     = 1'b0;
        memRe     = 1'b0;
        memAddr   = rdAddr;
        memWdata  = HostWrData;

        // Port arbitration: sweep owns the port; otherwise a host write always
        // beats the read, which simply reissues in S_ISSUE.
        if (state == S_CLEAR) begin
            memWe    = 1'b1;
            memAddr  = clrCnt[ADDR_W-1:0];
            memWdata = '0;
        end else if (HostWrEn) begin
            memWe    = 1'b1;
            memAddr  = HostWrAddr;
        end

        case (state)
            S_CLEAR: if (clrCnt == CLR_LAST) stateNext = S_IDLE;
            S_IDLE:  if (acceptReq) stateNext = S_ISSUE;
            S_ISSUE: begin
                if (!HostWrEn) begin
                    memRe     = 1'b1;
                    stateNext = S_WAIT;
                end
            end
            S_WAIT:  if (memRvalid) stateNext = S_DONE;
            S_DONE:  if (!RequestReadReg) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            clrCnt        <= '0;
            ClearBusy     <= 1'(CLEAR_ON_RESET != 0);
            rdAddr        <= '0;
            RegReadOutput <= '0;
            RegReadDone   <= 1'b0;
        end else begin
            if (state == S_CLEAR) begin
                clrCnt <= clrCnt + 1'b1;
                if (clrCnt == CLR_LAST)
                    ClearBusy <= 1'b0;
            end
            if (acceptReq)
                rdAddr <= RegReadAddr;
            if (state == S_WAIT && memRvalid) begin
                RegReadOutput <= memRdata;
                RegReadDone   <= 1'b1;
            end
            if (state == S_DONE && !RequestReadReg)
                RegReadDone <= 1'b0;
        end
    end

    ag32gbd_reg_bram #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) uBram (
        .sys_clock  (sys_clock),
        .sys_resetn (sys_resetn),
        .we         (memWe),
        .re         (memRe),
        .addr       (memAddr),
        .wdata      (memWdata),
        .rdata      (memRdata),
        .rvalid     (memRvalid)
    );

endmodule

// File: tb/tb_ag32gbd_reg_server.sv
module tb_ag32gbd_reg_server;
    import ag32gbd_pkg::*;

    logic       sys_clock = 1'b0;
    logic       sys_resetn;
    logic       HostWrEn;
    logic [9:0] HostWrAddr;
    logic [7:0] HostWrData;
    logic       RequestReadReg;
    logic [9:0] RegReadAddr;
    logic [7:0] RegReadOutput;
    logic       RegReadDone;
    logic       ClearBusy;

    int nChecks = 0;
    int nFails  = 0;
    logic [7:0] expQ[$];

    ag32gbd_reg_server #(
        .ADDR_W(10), .DATA_W(8), .RD_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut (
        .sys_clock      (sys_clock),
        .sys_resetn     (sys_resetn),
        .HostWrEn       (HostWrEn),
        .HostWrAddr     (HostWrAddr),
        .HostWrData     (HostWrData),
        .RequestReadReg (RequestReadReg),
        .RegReadAddr    (RegReadAddr),
        .RegReadOutput  (RegReadOutput),
        .RegReadDone    (RegReadDone),
        .ClearBusy      (ClearBusy)
    );

    always #5 sys_clock = ~sys_clock;

    // All tasks start and end on a falling edge; inputs change there and
    // outputs are sampled there.
    task automatic host_write(input logic [9:0] a, input logic [7:0] d);
        HostWrEn = 1'b1; HostWrAddr = a; HostWrData = d;
        @(negedge sys_clock);
        HostWrEn = 1'b0;
    endtask

    // Full handshake; reports latency, returned data, hold stability, drop.
    task automatic drive_read(input logic [9:0] a, input int hold, output int lat,
                              output logic [7:0] data, output logic heldOk,
                              output logic dropOk);
        RegReadAddr = a; RequestReadReg = 1'b1;
        lat = 0;
        do begin
            @(negedge sys_clock);
            lat++;
        end while (!RegReadDone && lat < 20);
        data = RegReadOutput;
        heldOk = 1'b1;
        repeat (hold) begin
            @(negedge sys_clock);
            if (RegReadDone !== 1'b1 || RegReadOutput !== data) heldOk = 1'b0;
        end
        RequestReadReg = 1'b0;
        @(negedge sys_clock);
        dropOk = (RegReadDone === 1'b0);
    endtask

    // Releases reset and returns how many cycles ClearBusy stayed high.
    task automatic run_sweep(output int busy, input logic doDropWr);
        sys_resetn = 1'b1;
        busy = 0;
        while (ClearBusy && busy < 3000) begin
            if (doDropWr && busy == 1000) begin
                HostWrEn = 1'b1; HostWrAddr = 10'h010; HostWrData = 8'h77;
            end else begin
                HostWrEn = 1'b0;
            end
            @(negedge sys_clock);
            busy++;
        end
        HostWrEn = 1'b0;
    endtask

    task automatic test_reset();
        nChecks++;
        if (RegReadDone !== 1'b0 || RegReadOutput !== 8'h00 || ClearBusy !== 1'b1) begin
            nFails++;
            $display("FAIL reset_state: done=%b out=%h busy=%b, want done=0 out=00 busy=1",
                     RegReadDone, RegReadOutput, ClearBusy);
        end
    endtask

    task automatic test_sweep();
        int busy, lat; logic [7:0] d; logic h, dr;
        run_sweep(busy, 1'b1);
        nChecks++;
        if (busy !== 1024) begin
            nFails++;
            $display("FAIL sweep_len: got %0d cycles, want 1024", busy);
        end
        expQ.push_back(8'h00);
        drive_read(10'h2A5, 0, lat, d, h, dr);
        nChecks++;
        if (d !== expQ.pop_front()) begin
            nFails++;
            $display("FAIL sweep_zero: got %h, want 00", d);
        end
        expQ.push_back(8'h00);
        drive_read(10'h010, 0, lat, d, h, dr);
        nChecks++;
        if (d !== expQ.pop_front()) begin
            nFails++;
            $display("FAIL sweep_drop_write: got %h, want 00", d);
        end
    endtask

    task automatic test_basic_read();
        int lat; logic [7:0] d, e; logic h, dr;
        host_write(THRESH_BASE, 8'h40);
        expQ.push_back(8'h40);
        drive_read(THRESH_BASE, 4, lat, d, h, dr);
        e = expQ.pop_front();
        nChecks++;
        if (lat !== 3) begin
            nFails++;
            $display("FAIL basic_latency: got %0d, want 3", lat);
        end
        nChecks++;
        if (d !== e) begin
            nFails++;
            $display("FAIL basic_data: got %h, want %h", d, e);
        end
        nChecks++;
        if (h !== 1'b1) begin
            nFails++;
            $display("FAIL basic_hold: got %b, want 1", h);
        end
        nChecks++;
        if (dr !== 1'b1) begin
            nFails++;
            $display("FAIL basic_drop: done low after drop got %b, want 1", dr);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] d, e; logic h, dr;
        host_write(10'h200, 8'h40);
        host_write(10'h201, 8'h80);
        host_write(10'h202, 8'hC0);
        expQ.push_back(8'h40); expQ.push_back(8'h80); expQ.push_back(8'hC0);
        for (int i = 0; i < 3; i++) begin
            drive_read(10'h200 + 10'(i), 1, lat, d, h, dr);
            e = expQ.pop_front();
            nChecks++;
            if (d !== e || lat !== 3 || dr !== 1'b1) begin
                nFails++;
                $display("FAIL b2b_%0d: data=%h lat=%0d drop=%b, want data=%h lat=3 drop=1",
                         i, d, lat, dr, e);
            end
        end
    endtask

    task automatic test_collision();
        int lat; logic [7:0] d, e;
        host_write(10'h203, 8'h11);
        expQ.push_back(8'h55);
        RegReadAddr = 10'h203; RequestReadReg = 1'b1;
        lat = 0;
        do begin
            @(negedge sys_clock);
            lat++;
            // One cycle after the request is sampled the FSM sits in S_ISSUE.
            if (lat == 1) begin
                HostWrEn = 1'b1; HostWrAddr = 10'h203; HostWrData = 8'h55;
            end else begin
                HostWrEn = 1'b0;
            end
        end while (!RegReadDone && lat < 20);
        HostWrEn = 1'b0;
        d = RegReadOutput;
        e = expQ.pop_front();
        RequestReadReg = 1'b0;
        @(negedge sys_clock);
        nChecks++;
        if (d !== e) begin
            nFails++;
            $display("FAIL collision_data: got %h, want %h", d, e);
        end
        nChecks++;
        if (lat !== 4) begin
            nFails++;
            $display("FAIL collision_latency: got %0d, want 4", lat);
        end
    endtask

    task automatic test_early_drop();
        int pulses, lat; logic [7:0] d, e; logic h, dr;
        host_write(10'h204, 8'h9A);
        expQ.push_back(8'h9A);
        RegReadAddr = 10'h204; RequestReadReg = 1'b1;
        @(negedge sys_clock);
        RequestReadReg = 1'b0;
        pulses = 0; d = 8'h00;
        repeat (8) begin
            @(negedge sys_clock);
            if (RegReadDone === 1'b1) begin
                pulses++;
                d = RegReadOutput;
            end
        end
        e = expQ.pop_front();
        nChecks++;
        if (pulses !== 1) begin
            nFails++;
            $display("FAIL early_drop_pulse: got %0d cycles, want 1", pulses);
        end
        nChecks++;
        if (d !== e) begin
            nFails++;
            $display("FAIL early_drop_data: got %h, want %h", d, e);
        end
        expQ.push_back(8'hC0);
        drive_read(10'h202, 2, lat, d, h, dr);
        e = expQ.pop_front();
        nChecks++;
        if (d !== e || lat !== 3 || h !== 1'b1) begin
            nFails++;
            $display("FAIL after_early_drop: data=%h lat=%0d hold=%b, want data=%h lat=3 hold=1",
                     d, lat, h, e);
        end
    endtask

    task automatic test_reset_mid_read();
        int busy, lat; logic [7:0] d; logic h, dr;
        RegReadAddr = 10'h201; RequestReadReg = 1'b1;
        @(negedge sys_clock);   // S_ISSUE
        @(negedge sys_clock);   // S_WAIT
        sys_resetn = 1'b0;
        RequestReadReg = 1'b0;
        #1;
        nChecks++;
        if (RegReadDone !== 1'b0 || RegReadOutput !== 8'h00 || ClearBusy !== 1'b1) begin
            nFails++;
            $display("FAIL reset_mid_read: done=%b out=%h busy=%b, want done=0 out=00 busy=1",
                     RegReadDone, RegReadOutput, ClearBusy);
        end
        @(negedge sys_clock);
        @(negedge sys_clock);
        run_sweep(busy, 1'b0);
        nChecks++;
        if (busy !== 1024) begin
            nFails++;
            $display("FAIL resweep_len: got %0d cycles, want 1024", busy);
        end
        expQ.push_back(8'h00);
        drive_read(10'h200, 0, lat, d, h, dr);
        nChecks++;
        if (d !== expQ.pop_front()) begin
            nFails++;
            $display("FAIL resweep_zero: got %h, want 00", d);
        end
    endtask

    initial begin
        sys_resetn = 1'b0;
        HostWrEn = 1'b0; HostWrAddr = '0; HostWrData = '0;
        RequestReadReg = 1'b0; RegReadAddr = '0;
        repeat (3) @(negedge sys_clock);
        test_reset();
        test_sweep();
        test_basic_read();
        test_back_to_back();
        test_collision();
        test_early_drop();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
